flash_page_sequencer: RTL

- Sequences the UART-to-flash bootstrap path.
- Owns the two page buffers (ping-pong RAM banks): selects which bank the UART fills and which bank the SPI engine drains.
- Issues SPI commands from the spi_pkg cmd_t set (NONE, ERASE, WRITE, END) and generates the flash page address.
- Handles partial final pages, end of stream and buffer overrun.

---
 rtl/flash_page_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/flash_page_sequencer.sv
// rtl/flash_page_sequencer.sv - ping-pong page buffer and SPI command sequencer for the UART-to-flash bootstrap
// Optional per-sector erase ahead of writes: define SECTOR_ERASE_EN.
package spi_pkg;
    typedef enum logic [1:0] {NONE = 2'd0, ERASE = 2'd1, WRITE = 2'd2, END = 2'd3} cmd_t;
endpackage

module flash_page_sequencer
    import spi_pkg::*;
#(
    parameter int          PAGE_BYTES   = 256,
    parameter int          ADDR_W       = 24,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int          SECTOR_BYTES = 4096
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          page_full,
    input  logic [$clog2(PAGE_BYTES)-1:0] byte_count,
    input  logic                          rx_timeout,
    output logic                          fill_bank,
    output logic                          drain_bank,
    output cmd_t                          spi_cmd,
    input  logic                          spi_done,
    output logic [ADDR_W-1:0]             spi_addr,
    output logic [$clog2(PAGE_BYTES):0]   page_len,
    output logic                          overrun,
    output logic                          finished
);
    localparam int CNT_W = $clog2(PAGE_BYTES);
    localparam int LEN_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] SECTOR_MASK = ADDR_W'(SECTOR_BYTES - 1);

    typedef enum logic [2:0] {ST_ERASE, ST_IDLE, ST_WRITE, ST_END, ST_DONE} state_t;

`ifdef SECTOR_ERASE_EN
    localparam bit     SECTOR_MODE = 1'b1;
    localparam state_t RST_STATE   = ST_IDLE;
    localparam cmd_t   RST_CMD     = NONE;
`else
    localparam bit     SECTOR_MODE = 1'b0;
    localparam state_t RST_STATE   = ST_ERASE;
    localparam cmd_t   RST_CMD     = ERASE;
`endif

    state_t           state;
    logic [1:0]       pending, pending_n;
    logic             final_seen, final_seen_n;
    logic [CNT_W-1:0] final_len, final_len_n;
    logic             fill_n, drain_n, overrun_n;
    logic             wr_done;
    logic [ADDR_W-1:0] next_addr;
    logic [LEN_W-1:0] issue_len;

    function automatic logic needs_erase(input logic [ADDR_W-1:0] addr);
        return SECTOR_MODE && ((addr & SECTOR_MASK) == '0);
    endfunction

    assign wr_done   = (state == ST_WRITE) && spi_done;
    assign next_addr = spi_addr + ADDR_W'(PAGE_BYTES);

    // Bank bookkeeping: a completed write frees a bank before same-cycle arrivals are judged.
    always_comb begin
        pending_n    = pending;
        fill_n       = fill_bank;
        drain_n      = drain_bank;
        overrun_n    = overrun;
        final_seen_n = final_seen;
        final_len_n  = final_len;
        if (state != ST_DONE) begin
            if (wr_done) begin
                pending_n = pending_n - 2'd1;
                drain_n   = ~drain_n;
            end
            if (page_full) begin
                if (pending_n < 2'd2) begin
                    pending_n = pending_n + 2'd1;
                    fill_n    = ~fill_n;
                end else begin
                    overrun_n = 1'b1;
                end
            end
            if (rx_timeout && !final_seen) begin
                final_seen_n = 1'b1;
                final_len_n  = byte_count;
                if (byte_count != '0) begin
                    if (pending_n < 2'd2) begin
                        pending_n = pending_n + 2'd1;
                        fill_n    = ~fill_n;
                    end else begin
                        overrun_n = 1'b1;
                    end
                end
            end
        end
    end

    // Only the partial bank, once it is the sole page left, is written short.
    assign issue_len = (final_seen_n && final_len_n != '0 && pending_n == 2'd1)
                     ? {1'b0, final_len_n} : LEN_W'(PAGE_BYTES);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= RST_STATE;
            spi_cmd    <= RST_CMD;
            spi_addr   <= ADDR_W'(BASE_ADDR);
            fill_bank  <= 1'b0;
            drain_bank <= 1'b0;
            page_len   <= LEN_W'(PAGE_BYTES);
            overrun    <= 1'b0;
            finished   <= 1'b0;
            pending    <= 2'd0;
            final_seen <= 1'b0;
            final_len  <= '0;
        end else begin
            pending    <= pending_n;
            fill_bank  <= fill_n;
            drain_bank <= drain_n;
            overrun    <= overrun_n;
            final_seen <= final_seen_n;
            final_len  <= final_len_n;
            case (state)
                ST_ERASE: if (spi_done) begin
                    if (SECTOR_MODE) begin
                        state    <= ST_WRITE;
                        spi_cmd  <= WRITE;
                        page_len <= issue_len;
                    end else begin
                        state   <= ST_IDLE;
                        spi_cmd <= NONE;
                    end
                end
                ST_IDLE: begin
                    if (pending != 2'd0) begin
                        if (needs_erase(spi_addr)) begin
                            state   <= ST_ERASE;
                            spi_cmd <= ERASE;
                        end else begin
                            state    <= ST_WRITE;
                            spi_cmd  <= WRITE;
                            page_len <= issue_len;
                        end
                    end else if (final_seen) begin
                        state   <= ST_END;
                        spi_cmd <= END;
                    end
                end
                ST_WRITE: if (spi_done) begin
                    spi_addr <= next_addr;
                    if (pending_n != 2'd0) begin
                        if (needs_erase(next_addr)) begin
                            state   <= ST_ERASE;
                            spi_cmd <= ERASE;
                        end else begin
                            spi_cmd  <= WRITE;
                            page_len <= issue_len;
                        end
                    end else begin
                        state   <= ST_IDLE;
                        spi_cmd <= NONE;
                    end
                end
                ST_END: if (spi_done) begin
                    finished <= 1'b1;
                    state    <= ST_DONE;
                    spi_cmd  <= NONE;
                end
                default: ;
            endcase
        end
    end
endmodule
